// File: rtl/spu_gbuf_pkg.sv
// spu_gbuf_pkg: shared definitions for the SPU global feature-map buffer.
//   - Default geometry (address/data width, depth, read latency).
//   - Clear-sweep FSM state encoding.
package spu_gbuf_pkg;

  localparam int unsigned GB_ADDR_WIDTH = 12;
  localparam int unsigned GB_DATA_WIDTH = 32;
  localparam int unsigned GB_DEPTH      = 4096;
  localparam int unsigned GB_RLATENCY   = 1;

  typedef enum logic [1:0] {
    GB_IDLE  = 2'b00,
    GB_CLEAR = 2'b01,
    GB_DONE  = 2'b10
  } gb_state_e;

endpackage

// File: rtl/spu_gbuf_rdpipe.sv
// spu_gbuf_rdpipe: RLATENCY-deep shift pipeline carrying {valid, err, data}
// for read responses of the global buffer.
//   core_clk  : clock, rising edge
//   rst_n     : asynchronous active-low reset; flushes all in-flight responses
//   in_valid  : read request sampled this cycle
//   in_err    : request was out of range
//   in_data   : array word (already zeroed for out-of-range requests)
//   out_valid : response valid, RLATENCY cycles after in_valid
//   out_err   : response belongs to an out-of-range request
//   out_data  : response data; holds its last value between responses
module spu_gbuf_rdpipe
  import spu_gbuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GB_DATA_WIDTH,
  parameter int unsigned RLATENCY   = GB_RLATENCY
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [RLATENCY-1:0]                 vld_q;
  logic [RLATENCY-1:0]                 err_q;
  logic [RLATENCY-1:0][DATA_WIDTH-1:0] data_q;

  // Data stages only load behind a valid entry, so the last stage naturally
  // holds the previous response when nothing is due.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      err_q[0] <= in_valid & in_err;
      if (in_valid) data_q[0] <= in_data;
      for (int unsigned i = 1; i < RLATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RLATENCY-1];
  assign out_err   = err_q[RLATENCY-1];
  assign out_data  = data_q[RLATENCY-1];

endmodule

// File: rtl/spu_gbuf_resp.sv
// spu_gbuf_resp: global feature-map buffer answering SPU gbuf master traffic.
// One read and one write port per cycle, fixed RLATENCY read latency,
// hardware zero-fill sweep, out-of-range detection.
//   core_clk    : clock, rising edge
//   rst_n       : asynchronous active-low reset (array contents not reset)
//   clr_start   : pulse, starts the zero-fill sweep (ignored unless idle)
//   clr_busy    : high for DEPTH cycles while the sweep runs
//   clr_end     : one-cycle pulse after the last word is cleared
//   gbuf_ren    : read request; gbuf_raddr its address
//   gbuf_rdata  : read data, valid when gbuf_rvalid is high
//   gbuf_rvalid : response strobe, RLATENCY cycles after gbuf_ren
//   gbuf_wen    : write request; gbuf_waddr/gbuf_wdata its address/data
//   gbuf_err    : pulse for an out-of-range access or a write dropped by the sweep
// Build option: define GBUF_RAW_BYPASS_EN to make a same-cycle read and write
// to the same in-range address return the new data (write-first); default
// is read-first.
module spu_gbuf_resp
  import spu_gbuf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = GB_DATA_WIDTH,
  parameter int unsigned DEPTH      = GB_DEPTH,
  parameter int unsigned RLATENCY   = GB_RLATENCY
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_end,
  input  logic                  gbuf_ren,
  input  logic [ADDR_WIDTH-1:0] gbuf_raddr,
  output logic [DATA_WIDTH-1:0] gbuf_rdata,
  output logic                  gbuf_rvalid,
  input  logic                  gbuf_wen,
  input  logic [ADDR_WIDTH-1:0] gbuf_waddr,
  input  logic [DATA_WIDTH-1:0] gbuf_wdata,
  output logic                  gbuf_err
);

  localparam int unsigned           IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  gb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clearing;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  ext_wr;
  logic                  werr_q;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_word;

  assign clearing = (state_q == GB_CLEAR);
  assign rd_ok    = ({1'b0, gbuf_raddr} < DEPTH_LIM);
  assign wr_ok    = ({1'b0, gbuf_waddr} < DEPTH_LIM);
  // The sweep owns the write port while it runs; external writes are dropped.
  assign ext_wr   = gbuf_wen & wr_ok & ~clearing;

  // Clear sweep FSM
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_end  = 1'b0;
    unique case (state_q)
      GB_IDLE: begin
        if (clr_start) begin
          state_d = GB_CLEAR;
          cnt_d   = '0;
        end
      end
      GB_CLEAR: begin
        clr_busy = 1'b1;
        if (cnt_q == LAST_ADDR) state_d = GB_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      GB_DONE: begin
        clr_end = 1'b1;
        state_d = GB_IDLE;
      end
      default: state_d = GB_IDLE;
    endcase
  end

  // Array write port (not reset)
  always_ff @(posedge core_clk) begin
    if (clearing)    mem[cnt_q[IDX_W-1:0]]      <= '0;
    else if (ext_wr) mem[gbuf_waddr[IDX_W-1:0]] <= gbuf_wdata;
  end

  // Array read: the word is sampled at the request edge, so a write on the
  // same edge is not yet visible (read-first) unless forwarded below.
  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = mem[gbuf_raddr[IDX_W-1:0]];
`ifdef GBUF_RAW_BYPASS_EN
    if (gbuf_ren && rd_ok && ext_wr && (gbuf_raddr == gbuf_waddr))
      rd_word = gbuf_wdata;
`endif
  end

  // Dropped writes flag one cycle after the request.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) werr_q <= 1'b0;
    else        werr_q <= gbuf_wen & (~wr_ok | clearing);
  end

  spu_gbuf_rdpipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RLATENCY   (RLATENCY)
  ) u_rdpipe (
    .core_clk  (core_clk),
    .rst_n     (rst_n),
    .in_valid  (gbuf_ren),
    .in_err    (~rd_ok),
    .in_data   (rd_word),
    .out_valid (gbuf_rvalid),
    .out_err   (rd_err),
    .out_data  (gbuf_rdata)
  );

  assign gbuf_err = werr_q | rd_err;

endmodule
